// File: rtl/cam_stream_gen_if.sv
// Camera pixel bus: the vsync/href/px_data pins between the emulator and a capture block.
interface cam_stream_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;

  modport master (output vsync, output href, output px_data);
  modport slave  (input  vsync, input  href, input  px_data);
endinterface

// File: rtl/cam_stream_gen.sv
// OV7670-style RGB565 frame generator driving vsync/href/px_data, high byte first.
// Optional: define CAM_STREAM_GEN_FRAME_ID_EN to stamp an 8-bit frame counter into byte 0 of line 0.
module cam_stream_gen #(
  parameter int unsigned H_PIX     = 160,
  parameter int unsigned V_LINES   = 120,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned VBP_LINES = 2,
  parameter int unsigned VFP_LINES = 2
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               pattern,
  input  logic [15:0]              color,
  cam_stream_gen_if.master         cam,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int unsigned LINE_LEN  = 2 * H_PIX + H_BLANK;
  localparam logic [15:0] LAST_BYTE = 16'(LINE_LEN - 1);
  localparam logic [15:0] ACT_BYTES = 16'(2 * H_PIX);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t      state_q, state_d;
  logic [15:0] byte_q, byte_d;
  logic [15:0] line_q, line_d;
  logic [15:0] phase_last;
  logic [1:0]  pat_q;
  logic [15:0] col_q;
  logic        latch, frame_end;

  logic [14:0] x;
  logic [2:0]  bar_idx;
  logic [15:0] pix, bar_col;
  logic        vs_d, href_d, busy_d;
  logic [7:0]  px_d;

`ifdef CAM_STREAM_GEN_FRAME_ID_EN
  logic [7:0] fid_q;
`endif

  always_comb begin
    phase_last = '0;
    case (state_q)
      VSYNC:   phase_last = 16'(VS_LINES - 1);
      VBP:     phase_last = 16'(VBP_LINES - 1);
      ACTIVE:  phase_last = 16'(V_LINES - 1);
      VFP:     phase_last = 16'(VFP_LINES - 1);
      default: phase_last = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    line_d    = line_q;
    latch     = 1'b0;
    frame_end = 1'b0;
    if (state_q == IDLE) begin
      byte_d = '0;
      line_d = '0;
      if (en) begin
        state_d = VSYNC;
        latch   = 1'b1;
      end
    end else if (byte_q == LAST_BYTE) begin
      byte_d = '0;
      if (line_q == phase_last) begin
        line_d = '0;
        case (state_q)
          VSYNC:  state_d = VBP;
          VBP:    state_d = ACTIVE;
          ACTIVE: state_d = VFP;
          VFP: begin
            frame_end = 1'b1;
            latch     = en;
            state_d   = en ? VSYNC : IDLE;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        line_d = line_q + 16'd1;
      end
    end else begin
      byte_d = byte_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      pat_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      if (latch) begin
        pat_q <= pattern;
        col_q <= color;
      end
    end
  end

  // Pixel generation from the current position; registered below so outputs trail state by one cycle.
  always_comb begin
    x       = byte_q[15:1];
    bar_idx = 3'({14'd0, x, 3'b000} / H_PIX);
    case (bar_idx)
      3'd0:    bar_col = 16'hFFFF;
      3'd1:    bar_col = 16'hFFE0;
      3'd2:    bar_col = 16'h07FF;
      3'd3:    bar_col = 16'h07E0;
      3'd4:    bar_col = 16'hF81F;
      3'd5:    bar_col = 16'hF800;
      3'd6:    bar_col = 16'h001F;
      default: bar_col = 16'h0000;
    endcase
    case (pat_q)
      2'd0:    pix = col_q;
      2'd1:    pix = bar_col;
      2'd2:    pix = {x[4:0], x[4:0], 1'b0, x[4:0]};
      default: pix = (x[3] ^ line_q[3]) ? 16'hFFFF : 16'h0000;
    endcase
    vs_d   = (state_q == VSYNC);
    href_d = (state_q == ACTIVE) && (byte_q < ACT_BYTES);
    busy_d = (state_q != IDLE);
    px_d   = '0;
    if (href_d) begin
      px_d = byte_q[0] ? pix[7:0] : pix[15:8];
`ifdef CAM_STREAM_GEN_FRAME_ID_EN
      if (line_q == '0 && byte_q == '0) px_d = fid_q;
`endif
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cam.vsync   <= 1'b0;
      cam.href    <= 1'b0;
      cam.px_data <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cam.vsync   <= vs_d;
      cam.href    <= href_d;
      cam.px_data <= px_d;
      frame_done  <= frame_end;
      busy        <= busy_d;
    end
  end

`ifdef CAM_STREAM_GEN_FRAME_ID_EN
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)           fid_q <= '0;
    else if (frame_end) fid_q <= fid_q + 8'd1;
  end
`endif

endmodule
